// File: rtl/riscv_pkg.sv
// Shared load/store size codes, LSU FSM states and the access legality check.
package riscv_pkg;

    // RISC-V funct3 size codes for loads and stores
    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_W  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE  = 2'd0,
        LSU_MERGE = 2'd1,
        LSU_DONE  = 2'd2
    } lsu_state_e;

    // 1 when the request must be rejected: unknown size code, unsigned
    // store codes, or an address not aligned to the access size.
    function automatic logic ldst_err(input logic we, input logic [2:0] size,
                                      input logic [1:0] off);
        logic err;
        err = 1'b0;
        case (size)
            LDST_B:  err = 1'b0;
            LDST_BU: err = we;
            LDST_H:  err = off[0];
            LDST_HU: err = we | off[0];
            LDST_W:  err = |off;
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane datapath: extracts/extends a load value from a word and merges
// sub-word store data into a word. Purely combinational.
module lsu_lane
    import riscv_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  size,
    input  logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic [31:0] st_data
);

    logic [4:0]  sh;
    logic [31:0] shifted;
    logic [31:0] mask;

    assign sh      = {off, 3'b000};
    assign shifted = word >> sh;

    // Load extend: select the addressed lane, then sign/zero extend
    always_comb begin
        ld_data = 32'h0;
        case (size)
            LDST_B:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
            LDST_H:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
            LDST_W:  ld_data = word;
            LDST_BU: ld_data = {24'h0, shifted[7:0]};
            LDST_HU: ld_data = {16'h0, shifted[15:0]};
            default: ld_data = 32'h0;
        endcase
    end

    // Store merge: replace only the addressed lane(s) of the old word
    always_comb begin
        mask = 32'hFFFF_FFFF;
        case (size[1:0])
            2'b00:   mask = 32'h0000_00FF << sh;
            2'b01:   mask = 32'h0000_FFFF << sh;
            default: mask = 32'hFFFF_FFFF;
        endcase
        st_data = (word & ~mask) | ((wdata << sh) & mask);
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: single-cycle loads and word stores, read-merge-
// write for byte/half stores, misalignment rejection.
module lsu_ctrl
    import riscv_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        misalign_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i
);

    lsu_state_e  state_q, state_d;
    // rd_q holds the extended load result, or the raw old word for a merge
    logic [31:0] rd_q, rd_d;
    // ld_q marks that rd_q is a load result to present in DONE
    logic        ld_q, ld_d;
    logic        err;
    logic [31:0] lane_word, lane_ld, lane_st;

    assign err       = ldst_err(core_we_i, core_size_i, core_addr_i[1:0]);
    assign lane_word = (state_q == LSU_MERGE) ? rd_q : mem_rd_i;

    lsu_lane u_lane (
        .word    (lane_word),
        .off     (core_addr_i[1:0]),
        .size    (core_size_i),
        .wdata   (core_wd_i),
        .ld_data (lane_ld),
        .st_data (lane_st)
    );

    // State and read register; reset also discards any pending merge
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= LSU_IDLE;
            rd_q    <= 32'h0;
            ld_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            ld_q    <= ld_d;
        end
    end

    // Next state and outputs; reset gates every output to 0 in the same cycle
    always_comb begin
        state_d      = state_q;
        rd_d         = rd_q;
        ld_d         = ld_q;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = 32'h0;
        mem_wd_o     = 32'h0;
        core_stall_o = 1'b0;
        misalign_o   = 1'b0;
        core_rd_o    = 32'h0;
        if (rst_i) begin
            state_d = LSU_IDLE;
            rd_d    = 32'h0;
            ld_d    = 1'b0;
        end else begin
            case (state_q)
                LSU_IDLE: begin
                    if (core_req_i) begin
                        core_stall_o = 1'b1;
                        state_d      = LSU_DONE;
                        ld_d         = 1'b0;
                        if (err) begin
                            misalign_o = 1'b1;
                            rd_d       = 32'h0;
                        end else begin
                            mem_req_o  = 1'b1;
                            mem_addr_o = {2'b00, core_addr_i[31:2]};
                            if (!core_we_i) begin
                                rd_d = lane_ld;
                                ld_d = 1'b1;
                            end else if (core_size_i == LDST_W) begin
                                mem_we_o = 1'b1;
                                mem_wd_o = core_wd_i;
                            end else begin
                                rd_d    = mem_rd_i;
                                state_d = LSU_MERGE;
                            end
                        end
                    end
                end
                LSU_MERGE: begin
                    mem_req_o    = 1'b1;
                    mem_we_o     = 1'b1;
                    mem_addr_o   = {2'b00, core_addr_i[31:2]};
                    mem_wd_o     = lane_st;
                    core_stall_o = 1'b1;
                    state_d      = LSU_DONE;
                end
                LSU_DONE: begin
                    core_rd_o = ld_q ? rd_q : 32'h0;
                    state_d   = LSU_IDLE;
                end
                default: state_d = LSU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized bench for lsu_ctrl against a word-array reference model.
module tb_lsu_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        core_req_i, core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i, core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o, misalign_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wd_o, mem_rd_i;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] mem [16];
    logic [31:0] ref_mem [16];
    logic        ld_en = 1'b0;
    logic [3:0]  ld_idx = 4'h0;
    logic [31:0] ld_val = 32'h0;

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Memory environment: preload port plus writes from the DUT
    always @(posedge clk_i) begin
        if (ld_en) mem[ld_idx] <= ld_val;
        else if (mem_req_o && mem_we_o) mem[mem_addr_o[3:0]] <= mem_wd_o;
    end
    assign mem_rd_i = mem[mem_addr_o[3:0]];

    lsu_ctrl dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .core_req_i   (core_req_i),
        .core_we_i    (core_we_i),
        .core_size_i  (core_size_i),
        .core_addr_i  (core_addr_i),
        .core_wd_i    (core_wd_i),
        .core_rd_o    (core_rd_o),
        .core_stall_o (core_stall_o),
        .misalign_o   (misalign_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wd_o     (mem_wd_o),
        .mem_rd_i     (mem_rd_i)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit ref_err(input bit we, input int size, input int addr);
        case (size)
            0: return 1'b0;
            4: return we;
            1: return (addr % 2) != 0;
            5: return we || ((addr % 2) != 0);
            2: return (addr % 4) != 0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input int size, input int addr, input logic [31:0] w);
        logic [31:0] v;
        v = w >> (8 * (addr % 4));
        case (size)
            0: return (v & 32'hFF) | ((v & 32'h80) != 0 ? 32'hFFFFFF00 : 32'h0);
            1: return (v & 32'hFFFF) | ((v & 32'h8000) != 0 ? 32'hFFFF0000 : 32'h0);
            4: return v & 32'hFF;
            5: return v & 32'hFFFF;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ref_store(input int size, input int addr,
                                              input logic [31:0] old, input logic [31:0] wd);
        logic [31:0] m;
        int sh;
        if (size == 2) return wd;
        sh = 8 * (addr % 4);
        m  = ((size == 0) ? 32'hFF : 32'hFFFF) << sh;
        return (old & ~m) | ((wd << sh) & m);
    endfunction

    // Issue one request at posedge+1 in IDLE; returns at posedge+1 after DONE
    task automatic run_req(input bit we, input int size, input int addr, input logic [31:0] wd,
                           output logic [31:0] rd_obs, output int stalls);
        bit err, done;
        int idx, reads, writes, mis;
        logic [31:0] exp_rd, exp_wd;
        idx    = (addr / 4) % 16;
        err    = ref_err(we, size, addr);
        exp_rd = (!err && !we) ? ref_load(size, addr, ref_mem[idx]) : 32'h0;
        exp_wd = (!err && we) ? ref_store(size, addr, ref_mem[idx], wd) : 32'h0;
        core_req_i  = 1'b1;
        core_we_i   = we;
        core_size_i = 3'(size);
        core_addr_i = 32'(addr);
        core_wd_i   = wd;
        stalls = 0; reads = 0; writes = 0; mis = 0; done = 1'b0; rd_obs = 32'h0;
        for (int c = 0; c < 6 && !done; c++) begin
            @(negedge clk_i);
            if (misalign_o) mis++;
            if (mem_req_o) begin
                chk("mem_addr", mem_addr_o, 32'(addr / 4));
                if (mem_we_o) begin
                    writes++;
                    chk("mem_wd", mem_wd_o, exp_wd);
                end else reads++;
            end
            if (core_stall_o) begin
                stalls++;
                @(posedge clk_i); #1;
            end else begin
                done   = 1'b1;
                rd_obs = core_rd_o;
            end
        end
        chk("done_reached", 32'(done), 32'd1);
        chk("stall_cycles", stalls, err ? 1 : ((we && size != 2) ? 2 : 1));
        chk("misalign_pulses", mis, 32'(err));
        chk("mem_reads", reads, (!err && (!we || size != 2)) ? 1 : 0);
        chk("mem_writes", writes, (!err && we) ? 1 : 0);
        chk("core_rd", rd_obs, exp_rd);
        if (!err && we) ref_mem[idx] = exp_wd;
        @(posedge clk_i); #1;
        core_req_i = 1'b0;
    endtask

    initial begin
        logic [31:0] rd, old;
        int st, c0;
        rst_i = 1'b1;
        core_req_i = 1'b1; core_we_i = 1'b1; core_size_i = 3'b001;
        core_addr_i = 32'h12; core_wd_i = 32'hFFFF_FFFF;
        for (int i = 0; i < 16; i++) begin
            ld_en  = 1'b1;
            ld_idx = 4'(i);
            ld_val = (i == 4) ? 32'h8899AABB : $urandom;
            ref_mem[i] = ld_val;
            @(posedge clk_i); #1;
        end
        ld_en = 1'b0;
        // Outputs forced low during reset even with a request pending
        @(negedge clk_i);
        chk("rst_mem_req", 32'(mem_req_o), 0);
        chk("rst_mem_we", 32'(mem_we_o), 0);
        chk("rst_stall", 32'(core_stall_o), 0);
        chk("rst_misalign", 32'(misalign_o), 0);
        chk("rst_rd", core_rd_o, 0);
        chk("rst_wd", mem_wd_o, 0);
        chk("rst_addr", mem_addr_o, 0);
        @(posedge clk_i); #1;
        rst_i = 1'b0; core_req_i = 1'b0;
        @(negedge clk_i);
        chk("idle_stall", 32'(core_stall_o), 0);
        chk("idle_mem_req", 32'(mem_req_o), 0);
        @(posedge clk_i); #1;

        run_req(0, 0, 'h12, 0, rd, st);
        chk("lb_0x12", rd, 32'hFFFFFF99);
        chk("lb_stall", st, 1);
        run_req(0, 5, 'h12, 0, rd, st);
        chk("lhu_0x12", rd, 32'h00008899);
        run_req(0, 2, 'h10, 0, rd, st);
        chk("lw_0x10", rd, 32'h8899AABB);
        run_req(1, 0, 'h11, 32'h55, rd, st);
        chk("sb_mem", mem[4], 32'h889955BB);
        chk("sb_stall", st, 2);
        run_req(1, 2, 'h13, 32'h12345678, rd, st);
        chk("sw_mis_rd", rd, 0);
        chk("sw_mis_mem", mem[4], 32'h889955BB);

        // Reset during MERGE must suppress the write
        old = mem[8];
        core_req_i = 1'b1; core_we_i = 1'b1; core_size_i = 3'b001;
        core_addr_i = 32'h20; core_wd_i = 32'h1234;
        @(negedge clk_i);
        chk("sh_rd_cycle_we", 32'(mem_we_o), 0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("merge_rst_we", 32'(mem_we_o), 0);
        chk("merge_rst_req", 32'(mem_req_o), 0);
        @(posedge clk_i); #1;
        rst_i = 1'b0; core_req_i = 1'b0;
        @(negedge clk_i);
        chk("post_rst_stall", 32'(core_stall_o), 0);
        chk("post_rst_mem", mem[8], old);
        @(posedge clk_i); #1;

        // Back-to-back LW then SW
        c0 = cyc;
        run_req(0, 2, 'h10, 0, rd, st);
        chk("b2b_lw", rd, 32'h889955BB);
        run_req(1, 2, 'h10, 32'hDEADBEEF, rd, st);
        chk("b2b_cycles", cyc - c0, 4);
        chk("b2b_mem", mem[4], 32'hDEADBEEF);

        for (int n = 0; n < 200; n++)
            run_req(bit'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 63),
                    $urandom, rd, st);
        for (int i = 0; i < 16; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have ports: clk_i  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst_i  in  1  reset, synchronous and active-high.
REQ-003 SHALL have ports: core_req_i in 1 (access request); core_we_i in 1 (1=store); core_size_i in 3 (RISC-V funct3 size code); core_addr_i in 32 (byte address); core_wd_i in 32 (store data, LSB-justified).
REQ-004 SHALL have ports: core_rd_o out 32 (load result, extended); core_stall_o out 1 (core holds request stable while 1); misalign_o out 1 (one-cycle error pulse).
REQ-005 SHALL have ports: mem_req_o out 1; mem_we_o out 1; mem_addr_o out 32 (word index); mem_wd_o out 32; mem_rd_i in 32 (word read data, combinational, same cycle as mem_req_o with mem_we_o=0).

Function
REQ-006 SHALL decode core_size_i: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; for stores only 000 SB, 001 SH, 010 SW are legal.
REQ-007 SHALL drive mem_addr_o = {2'b00, core_addr_i[31:2]} whenever mem_req_o=1.
REQ-008 SHALL implement FSM states IDLE, MERGE, DONE; reset state IDLE.
REQ-009 IDLE, core_req_i=0: all mem_* outputs 0, core_stall_o=0, stay IDLE.
REQ-010 IDLE, legal load: mem_req_o=1, mem_we_o=0, capture mem_rd_i into read register, core_stall_o=1, -> DONE.
REQ-011 IDLE, legal SW: mem_req_o=1, mem_we_o=1, mem_wd_o=core_wd_i, core_stall_o=1, -> DONE.
REQ-012 IDLE, legal SB/SH: mem_req_o=1, mem_we_o=0, capture mem_rd_i, core_stall_o=1, -> MERGE.
REQ-013 MERGE: mem_req_o=1, mem_we_o=1, mem_wd_o = captured word with byte lane(s) selected by core_addr_i[1:0] replaced by core_wd_i[7:0] or [15:0]; core_stall_o=1; -> DONE.
REQ-014 DONE: core_stall_o=0, no memory access, core_rd_o valid; core_req_i ignored; -> IDLE unconditionally.
REQ-015 Load result: byte/half selected by core_addr_i[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes word; core_rd_o SHALL hold this value in DONE and 0 in all other states.
REQ-016 Misalignment: LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=0, or illegal size code SHALL issue no memory access, pulse misalign_o=1 for the IDLE cycle, stall 1 cycle, -> DONE with core_rd_o=0.
REQ-017 Every access SHALL stall exactly 1 cycle (loads, SW, errors) or 2 cycles (SB/SH); no write is ever issued twice per request.
REQ-018 Back-to-back requests: request presented in the cycle after DONE SHALL be accepted in IDLE normally.

Reset
REQ-019 While rst_i=1, SHALL force mem_req_o=0, mem_we_o=0, core_stall_o=0, misalign_o=0, core_rd_o=0, mem_wd_o=0, mem_addr_o=0.
REQ-020 Reset in any state (incl. MERGE) SHALL return FSM to IDLE next edge and clear read register; an interrupted SB/SH SHALL not write memory.

Structure
REQ-021 Size codes (LDST_B, LDST_H, LDST_W, LDST_BU, LDST_HU) and FSM state enum SHALL live in shared package riscv_pkg.
REQ-022 Byte-lane extract/extend and merge logic SHALL be one sub-module lsu_lane (combinational, reused for load extend and store merge).

Verification
REQ-023 Word [0x10]=0x8899AABB; LB addr 0x12 -> mem_addr_o=4, stall 1 cycle, core_rd_o=0xFFFFFF99.
REQ-024 Same word; LHU addr 0x12 -> core_rd_o=0x00008899; LW 0x10 -> 0x8899AABB.
REQ-025 SB addr 0x11 data 0x55 -> read cycle, write cycle mem_wd_o=0x8899<55>BB i.e. 0x889955BB, stall 2 cycles.
REQ-026 SW addr 0x13 -> misalign_o pulse, no mem_req_o, core_rd_o=0, stall 1 cycle.
REQ-027 SH issued, rst_i asserted during MERGE -> no mem_we_o=1 cycle, FSM IDLE, memory word unchanged.
REQ-028 LW followed immediately by SW on next IDLE cycle -> both complete, total 4 cycles, correct data.
